seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl_pkg.sv | 20 ++
 rtl/seg_scan_ctrl_hex7seg.sv | 11 +
 rtl/seg_scan_ctrl.sv | 97 +++++++++
 tb/tb_seg_scan_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed 8-digit hex display scanner.
package seg_scan_ctrl_pkg;

  typedef enum logic {
    SCAN_BLANK = 1'b0,
    SCAN_SHOW  = 1'b1
  } scan_state_t;

  localparam int NUM_DIGITS = 8;

  localparam logic [7:0] AN_OFF  = 8'hFF;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // active-low {dp,g,f,e,d,c,b,a}, dp off
  localparam logic [7:0] HEX_TAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/seg_scan_ctrl_hex7seg.sv
// Combinational 4-bit code to active-low seven-segment pattern.
module hex7seg
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] code,
  output logic [7:0] seg
);

  assign seg = HEX_TAB[code];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-byte display buffer shared by a keyboard shifter and a CPU port,
// scanned onto eight multiplexed hex digits with a blanking gap per slot.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int BLANK = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kbd_valid,
  input  logic [7:0] kbd_data,
  input  logic       cpu_we,
  input  logic [1:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  input  logic       cpu_lock,
  output logic       cpu_ack,
  output logic       kbd_drop,
  output logic [7:0] SEG,
  output logic [7:0] AN
);

  localparam int DIG_W = $clog2(NUM_DIGITS);

  logic [7:0]       byte_buf [4];
  logic             pend_q;
  logic             shift;
  logic             cpu_wr;
  logic [15:0]      tick;
  logic [DIG_W-1:0] dig;
  scan_state_t      state;
  logic [7:0]       sel_byte;
  logic [3:0]       nibble;
  logic [7:0]       hex_seg;

  // A write deferred by a keyboard shift owns the next cycle outright.
  assign shift  = kbd_valid & ~cpu_lock & ~pend_q;
  assign cpu_wr = cpu_we & ~shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) byte_buf[i] <= '0;
      pend_q   <= 1'b0;
      cpu_ack  <= 1'b0;
      kbd_drop <= 1'b0;
    end else begin
      if (shift) begin
        byte_buf[0] <= kbd_data;
        byte_buf[1] <= byte_buf[0];
        byte_buf[2] <= byte_buf[1];
        byte_buf[3] <= byte_buf[2];
      end else if (cpu_we) begin
        byte_buf[cpu_addr] <= cpu_wdata;
      end
      pend_q   <= shift & cpu_we;
      cpu_ack  <= cpu_wr;
      kbd_drop <= kbd_valid & ~shift;
    end
  end

  assign sel_byte = byte_buf[dig[DIG_W-1:1]];
  assign nibble   = dig[0] ? sel_byte[7:4] : sel_byte[3:0];

  hex7seg u_hex (
    .code (nibble),
    .seg  (hex_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick  <= '0;
      dig   <= '0;
      state <= SCAN_BLANK;
      AN    <= AN_OFF;
      SEG   <= SEG_OFF;
    end else begin
      tick <= (tick == 16'(DIV - 1)) ? '0 : tick + 16'd1;
      case (state)
        SCAN_BLANK: begin
          AN  <= AN_OFF;
          SEG <= SEG_OFF;
          if (tick == 16'(BLANK - 1)) state <= SCAN_SHOW;
        end
        SCAN_SHOW: begin
          AN  <= ~(8'b1 << dig);
          SEG <= hex_seg;
          if (tick == 16'(DIV - 1)) begin
            state <= SCAN_BLANK;
            dig   <= dig + 1'b1;
          end
        end
        default: state <= SCAN_BLANK;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a slot-arithmetic display model.
module tb_seg_scan_ctrl;

  localparam int DIV_T   = 8;
  localparam int BLANK_T = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kbd_valid = 1'b0;
  logic [7:0] kbd_data = 8'h00;
  logic       cpu_we = 1'b0;
  logic [1:0] cpu_addr = 2'd0;
  logic [7:0] cpu_wdata = 8'h00;
  logic       cpu_lock = 1'b0;
  logic       cpu_ack, kbd_drop;
  logic [7:0] SEG, AN;

  seg_scan_ctrl #(.DIV(DIV_T), .BLANK(BLANK_T)) dut (
    .clk(clk), .rst(rst), .kbd_valid(kbd_valid), .kbd_data(kbd_data),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_lock(cpu_lock), .cpu_ack(cpu_ack), .kbd_drop(kbd_drop),
    .SEG(SEG), .AN(AN)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int misc    = 0;

  logic [7:0] hex_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Reference: position in the scan follows from the cycle count since reset.
  logic [7:0] m_buf [4];
  bit         m_pend;
  int         m_n;
  logic [7:0] e_an, e_seg;
  logic       e_ack, e_drop;
  int         m_tick, m_dig;
  logic [7:0] m_byte;
  logic [3:0] m_nib;
  bit         kbd_taken, cpu_taken;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m_buf[i] = 8'h00;
      m_pend = 0; m_n = 0;
      e_an = 8'hFF; e_seg = 8'hFF; e_ack = 1'b0; e_drop = 1'b0;
    end else begin
      m_tick = m_n % DIV_T;
      m_dig  = (m_n / DIV_T) % 8;
      m_byte = m_buf[m_dig / 2];
      m_nib  = (m_dig % 2 == 1) ? m_byte[7:4] : m_byte[3:0];
      if (m_tick >= BLANK_T) begin
        e_an  = ~(8'h01 << m_dig);
        e_seg = hex_tab[m_nib];
      end else begin
        e_an  = 8'hFF;
        e_seg = 8'hFF;
      end
      kbd_taken = kbd_valid && !cpu_lock && !m_pend;
      cpu_taken = cpu_we && !kbd_taken;
      e_drop = kbd_valid && !kbd_taken;
      e_ack  = cpu_taken;
      if (kbd_taken) begin
        m_buf[3] = m_buf[2]; m_buf[2] = m_buf[1];
        m_buf[1] = m_buf[0]; m_buf[0] = kbd_data;
      end
      if (cpu_taken) m_buf[cpu_addr] = cpu_wdata;
      m_pend = kbd_taken && cpu_we;
      m_n++;
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_an", AN, e_an);
      chk("model_seg", SEG, e_seg);
      chk("model_ack", {7'd0, cpu_ack}, {7'd0, e_ack});
      chk("model_drop", {7'd0, kbd_drop}, {7'd0, e_drop});
    end
  end

  task automatic wait_an(input logic [7:0] v, input int budget, input string nm);
    int k = 0;
    while (AN !== v && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(nm, AN, v);
  endtask

  task automatic idle();
    kbd_valid = 1'b0; cpu_we = 1'b0;
  endtask

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int ff_cnt, bad_onehot, order_err;
  logic [7:0] last_an;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_an", AN, 8'hFF);
    chk("rst_seg", SEG, 8'hFF);
    chk("rst_ack", {7'd0, cpu_ack}, 8'h00);
    chk("rst_drop", {7'd0, kbd_drop}, 8'h00);
    rst = 1'b0;

    // keyboard fill: 1C, F0, 1C
    kbd_valid = 1'b1; kbd_data = 8'h1C;
    @(negedge clk); kbd_data = 8'hF0;
    @(negedge clk); kbd_data = 8'h1C;
    @(negedge clk); idle();
    wait_an(8'hFD, 40, "d1_an");
    chk("d1_seg", SEG, 8'hF9);
    wait_an(8'hFE, 80, "d0_an");
    chk("d0_seg", SEG, 8'hC6);

    // 64-cycle scan sweep
    ff_cnt = 0; bad_onehot = 0; order_err = 0; last_an = 8'hFE;
    for (int i = 0; i < 64; i++) begin
      if (AN == 8'hFF) ff_cnt++;
      else begin
        if ($countones(~AN) != 1) bad_onehot++;
        if (AN != last_an && AN != {last_an[6:0], last_an[7]}) order_err++;
        last_an = AN;
      end
      @(negedge clk);
    end
    chk("blank_cycles", 8'(ff_cnt), 8'd16);
    chk("onehot", 8'(bad_onehot), 8'd0);
    chk("digit_order", 8'(order_err), 8'd0);

    // kbd/cpu conflict then deferral
    kbd_valid = 1'b1; kbd_data = 8'h55;
    cpu_we = 1'b1; cpu_addr = 2'd2; cpu_wdata = 8'hAA;
    @(negedge clk);
    chk("conf_noack", {7'd0, cpu_ack}, 8'h00);
    kbd_data = 8'h12;
    @(negedge clk);
    chk("defer_ack", {7'd0, cpu_ack}, 8'h01);
    chk("defer_drop", {7'd0, kbd_drop}, 8'h01);
    idle();
    @(negedge clk);
    chk("defer_ack_end", {7'd0, cpu_ack}, 8'h00);
    chk("mbuf0", m_buf[0], 8'h55);
    chk("mbuf1", m_buf[1], 8'h1C);
    chk("mbuf2", m_buf[2], 8'hAA);
    chk("mbuf3", m_buf[3], 8'h1C);

    // lock
    cpu_lock = 1'b1; kbd_valid = 1'b1; kbd_data = 8'h33;
    @(negedge clk); kbd_valid = 1'b0;
    chk("lock_drop", {7'd0, kbd_drop}, 8'h01);
    @(negedge clk);
    chk("lock_drop_end", {7'd0, kbd_drop}, 8'h00);
    cpu_we = 1'b1; cpu_addr = 2'd0; cpu_wdata = 8'h7E;
    @(negedge clk);
    chk("lock_ack", {7'd0, cpu_ack}, 8'h01);
    cpu_we = 1'b0;
    @(negedge clk);
    chk("lock_ack_end", {7'd0, cpu_ack}, 8'h00);
    chk("mbuf0_lock", m_buf[0], 8'h7E);
    wait_an(8'hFE, 80, "lock_d0_an");
    chk("lock_d0_seg", SEG, 8'h86);
    cpu_lock = 1'b0;

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      kbd_valid = ($urandom_range(0, 3) == 0);
      kbd_data  = 8'($urandom);
      if ($urandom_range(0, 19) == 0) cpu_lock = ~cpu_lock;
      if (m_pend) begin
        cpu_we = 1'b1;
      end else begin
        cpu_we    = ($urandom_range(0, 3) == 0);
        cpu_addr  = 2'($urandom);
        cpu_wdata = 8'($urandom);
      end
    end
    @(negedge clk);
    idle(); cpu_lock = 1'b0;

    // asynchronous reset mid-SHOW on digit 5
    wait_an(8'hDF, 80, "d5_an");
    #1 rst = 1'b1;
    #1;
    chk("async_an", AN, 8'hFF);
    chk("async_seg", SEG, 8'hFF);
    chk("async_ack", {7'd0, cpu_ack}, 8'h00);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    begin
      int k = 0;
      while (AN === 8'hFF && k < 20) begin
        @(negedge clk);
        k++;
      end
    end
    chk("restart_an", AN, 8'hFE);
    chk("restart_seg", SEG, 8'hC0);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
